// File: rtl/byte_fifo_pkg.sv
// byte_fifo_pkg
//   Shared constants and types for the byte FIFO: default data width and
//   depth, the data word type and the pointer/count types sized from them.
package byte_fifo_pkg;

    localparam int BF_WIDTH = 8;
    localparam int BF_DEPTH = 8;
    localparam int BF_PTR_W = $clog2(BF_DEPTH);
    localparam int BF_CNT_W = BF_PTR_W + 1;

    typedef logic [BF_WIDTH-1:0] data_t;
    typedef logic [BF_PTR_W-1:0] ptr_t;
    typedef logic [BF_CNT_W-1:0] cnt_t;

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo
//   Synchronous first-word-fall-through FIFO with sticky overflow/underflow
//   error flags.
//
//   Ports
//     clk        rising-edge clock
//     reset      asynchronous active-low reset (clears pointers, count, flags)
//     din        write data
//     wr_en      write request
//     rd_en      read request
//     clr_flags  synchronous clear of overflow/underflow (a new set wins)
//     dout       head-of-queue data, zero while empty
//     empty      count == 0
//     full       count == DEPTH
//     count      number of stored entries
//     overflow   sticky: a write was rejected
//     underflow  sticky: a read was rejected
module byte_fifo
    import byte_fifo_pkg::*;
#(
    parameter int WIDTH = BF_WIDTH,
    parameter int DEPTH = BF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         din,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic                     clr_flags,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PW = $clog2(DEPTH);

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [PW-1:0]    fptr_t;
    typedef logic [PW:0]      fcnt_t;

    localparam fptr_t PTR_ONE  = fptr_t'(1);
    localparam fcnt_t CNT_ONE  = fcnt_t'(1);
    localparam fcnt_t CNT_FULL = fcnt_t'(DEPTH);

    word_t mem_r [DEPTH];
    fptr_t wr_ptr_r;
    fptr_t rd_ptr_r;
    fcnt_t count_r;
    logic  ovf_r;
    logic  udf_r;

    logic  empty_s;
    logic  full_s;
    logic  rd_acc_s;
    logic  wr_acc_s;
    logic  wr_rej_s;
    logic  rd_rej_s;

    // Status from registered count and accept/reject decisions for this edge.
    // A write into a full queue is still accepted when a read frees a slot.
    always_comb begin
        empty_s  = (count_r == fcnt_t'(0));
        full_s   = (count_r == CNT_FULL);
        rd_acc_s = rd_en & ~empty_s;
        wr_acc_s = wr_en & (~full_s | rd_acc_s);
        wr_rej_s = wr_en & ~wr_acc_s;
        rd_rej_s = rd_en & empty_s;
    end

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r] <= din;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers and occupancy count; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= fptr_t'(0);
            rd_ptr_r <= fptr_t'(0);
            count_r  <= fcnt_t'(0);
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky error flags: a new rejection outranks a coincident clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            if (wr_rej_s) begin
                ovf_r <= 1'b1;
            end else if (clr_flags) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
            if (rd_rej_s) begin
                udf_r <= 1'b1;
            end else if (clr_flags) begin
                udf_r <= 1'b0;
            end else begin
                udf_r <= udf_r;
            end
        end
    end

    // Fall-through head data, forced to zero while nothing is queued.
    always_comb begin
        if (empty_s) begin
            dout = {WIDTH{1'b0}};
        end else begin
            dout = mem_r[rd_ptr_r];
        end
    end

    assign empty     = empty_s;
    assign full      = full_s;
    assign count     = count_r;
    assign overflow  = ovf_r;
    assign underflow = udf_r;

endmodule

// File: tb/tb_byte_fifo.sv
// tb_byte_fifo
//   Self-checking bench for byte_fifo. A queue-based reference model tracks
//   the expected contents and sticky flags; scenario tasks compare the DUT
//   against it and against fixed expected values.
module tb_byte_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] din;
    logic             wr_en;
    logic             rd_en;
    logic             clr_flags;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic             full;
    logic [3:0]       count;
    logic             overflow;
    logic             underflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mq[$];
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;

    byte_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .clr_flags(clr_flags), .dout(dout), .empty(empty), .full(full),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] m_head();
        if (mq.size() == 0) return 8'h00;
        return mq[0];
    endfunction

    // Drive one cycle, update the model by the queue rules, sample at edge+1.
    task automatic step(input logic w, input logic r, input logic [7:0] d, input logic c);
        bit racc;
        bit wacc;
        wr_en = w; rd_en = r; din = d; clr_flags = c;
        racc = r && (mq.size() > 0);
        wacc = w && ((mq.size() < DEPTH) || racc);
        @(posedge clk);
        if (racc) void'(mq.pop_front());
        if (wacc) mq.push_back(d);
        if (w && !wacc) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
        if (r && !racc) m_udf = 1'b1; else if (c) m_udf = 1'b0;
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clr_flags = 1'b0; din = 8'h00;
    endtask

    task automatic test_reset();
        reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_flags = 1'b0; din = 8'h00;
        #2;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout got=%h exp=00", dout); end
        n_checks++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got=%b exp=00", {overflow, underflow}); end
        #10;
        reset = 1'b1;
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 8'(i), 1'b0);
            n_checks++; if (count !== 4'(i + 1)) begin n_fail++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, i + 1); end
            n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL fill_dout i=%0d got=%h exp=00", i, dout); end
        end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full got=%b exp=1", full); end
        n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL fill_empty got=%b exp=0", empty); end
        step(1'b1, 1'b0, 8'hFF, 1'b0);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL ovf_count got=%0d exp=8", count); end
    endtask

    task automatic test_drain_underflow();
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++; if (dout !== 8'(i)) begin n_fail++; $display("FAIL drain_dout i=%0d got=%h exp=%h", i, dout, 8'(i)); end
            step(1'b0, 1'b1, 8'h00, 1'b0);
            n_checks++; if (count !== 4'(DEPTH - 1 - i)) begin n_fail++; $display("FAIL drain_count i=%0d got=%0d exp=%0d", i, count, DEPTH - 1 - i); end
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got=%b exp=1", empty); end
        n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL drain_dout0 got=%h exp=00", dout); end
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL drain_udf_early got=%b exp=0", underflow); end
        step(1'b0, 1'b1, 8'h00, 1'b0);
        n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL udf_set got=%b exp=1", underflow); end
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL udf_count got=%0d exp=0", count); end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        n_checks++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL clr_both got=%b exp=00", {overflow, underflow}); end
    endtask

    task automatic test_wrap();
        int plan[4][2] = '{'{1, 8}, '{0, 5}, '{1, 5}, '{0, 8}};
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < plan[p][1]; k++) begin
                if (plan[p][0] == 1) begin
                    step(1'b1, 1'b0, 8'($urandom_range(255)), 1'b0);
                end else begin
                    n_checks++; if (dout !== m_head()) begin n_fail++; $display("FAIL wrap_dout p=%0d k=%0d got=%h exp=%h", p, k, dout, m_head()); end
                    step(1'b0, 1'b1, 8'h00, 1'b0);
                end
                n_checks++; if (count !== 4'(mq.size())) begin n_fail++; $display("FAIL wrap_count p=%0d k=%0d got=%0d exp=%0d", p, k, count, mq.size()); end
            end
        end
        n_checks++; if ({count, overflow, underflow} !== 6'b0) begin n_fail++; $display("FAIL wrap_end got=%0d/%b%b exp=0/00", count, overflow, underflow); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] last;
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'($urandom_range(255)), 1'b0);
        step(1'b1, 1'b1, 8'hAA, 1'b0);
        n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL simfull_count got=%0d exp=8", count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL simfull_ovf got=%b exp=0", overflow); end
        last = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++; if (dout !== m_head()) begin n_fail++; $display("FAIL simfull_dout i=%0d got=%h exp=%h", i, dout, m_head()); end
            last = dout;
            step(1'b0, 1'b1, 8'h00, 1'b0);
        end
        n_checks++; if (last !== 8'hAA) begin n_fail++; $display("FAIL simfull_last got=%h exp=aa", last); end
        step(1'b1, 1'b1, 8'h55, 1'b0);
        n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL simempty_count got=%0d exp=1", count); end
        n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL simempty_udf got=%b exp=1", underflow); end
        n_checks++; if (dout !== 8'h55) begin n_fail++; $display("FAIL simempty_dout got=%h exp=55", dout); end
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b0, 8'h11, 1'b0);
        step(1'b1, 1'b0, 8'h22, 1'b0);
        n_checks++; if (count !== 4'd3) begin n_fail++; $display("FAIL ar_pre_count got=%0d exp=3", count); end
        #2 reset = 1'b0;
        mq.delete(); m_ovf = 1'b0; m_udf = 1'b0;
        #1;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ar_empty got=%b exp=1", empty); end
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL ar_count got=%0d exp=0", count); end
        n_checks++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL ar_flags got=%b exp=00", {overflow, underflow}); end
        n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL ar_dout got=%h exp=00", dout); end
        #3 reset = 1'b1;
        step(1'b1, 1'b0, 8'h3C, 1'b0);
        n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL ar_post_count got=%0d exp=1", count); end
        n_checks++; if (dout !== 8'h3C) begin n_fail++; $display("FAIL ar_post_dout got=%h exp=3c", dout); end
    endtask

    task automatic test_clr_flags();
        while (mq.size() < DEPTH) step(1'b1, 1'b0, 8'($urandom_range(255)), 1'b0);
        step(1'b1, 1'b0, 8'h01, 1'b0);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL clr_ovf_set got=%b exp=1", overflow); end
        step(1'b1, 1'b0, 8'h02, 1'b1);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL clr_setwins got=%b exp=1", overflow); end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_alone got=%b exp=0", overflow); end
        n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL clr_count got=%0d exp=8", count); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(99) < 55), 1'($urandom_range(99) < 50),
                 8'($urandom_range(255)), 1'($urandom_range(99) < 8));
            n_checks++; if (count !== 4'(mq.size())) begin n_fail++; $display("FAIL rnd_count i=%0d got=%0d exp=%0d", i, count, mq.size()); end
            n_checks++; if (dout !== m_head()) begin n_fail++; $display("FAIL rnd_dout i=%0d got=%h exp=%h", i, dout, m_head()); end
            n_checks++; if ({empty, full} !== {mq.size() == 0, mq.size() == DEPTH}) begin n_fail++; $display("FAIL rnd_ef i=%0d got=%b%b exp=%b%b", i, empty, full, mq.size() == 0, mq.size() == DEPTH); end
            n_checks++; if ({overflow, underflow} !== {m_ovf, m_udf}) begin n_fail++; $display("FAIL rnd_flags i=%0d got=%b%b exp=%b%b", i, overflow, underflow, m_ovf, m_udf); end
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_wrap();
        test_simultaneous();
        test_async_reset();
        test_clr_flags();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
